// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. It forwards ALU operands from EX/MEM and MEM/WB,
// detects load-use hazards, and turns flush, reset and hazard cycles into bubbles.
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CTRL_W = 4,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [CTRL_W-1:0] id_alu_control,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              flush,
    input  logic              stall,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] ex_pc,
    output logic [CTRL_W-1:0] ex_alu_control,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] input_data_1,
    output logic [DATA_W-1:0] input_data_2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              load_use_stall
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] alu_control;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
    } stage_t;

    stage_t q;
    stage_t captured;
    logic [DATA_W-1:0] fwd_rs1;
    logic [DATA_W-1:0] fwd_rs2;

    // A non-valid ID slot must never write state, so its side-effect controls are masked.
    always_comb begin
        captured             = '0;
        captured.valid       = id_valid;
        captured.pc          = id_pc;
        captured.rs1_data    = id_rs1_data;
        captured.rs2_data    = id_rs2_data;
        captured.imm         = id_imm;
        captured.rs1         = id_rs1;
        captured.rs2         = id_rs2;
        captured.rd          = id_rd;
        captured.alu_control = id_alu_control;
        captured.alu_src     = id_alu_src;
        captured.reg_write   = id_reg_write & id_valid;
        captured.mem_read    = id_mem_read  & id_valid;
        captured.mem_write   = id_mem_write & id_valid;
        captured.branch      = id_branch    & id_valid;
    end

    always_comb begin
        load_use_stall = id_valid & q.valid & q.mem_read & (q.rd != '0) &
                         ((q.rd == id_rs1) | (q.rd == id_rs2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (stall) begin
            q <= q;
        end else if (load_use_stall) begin
            q <= '0;
        end else begin
            q <= captured;
        end
    end

    // EX/MEM holds the younger result, so it takes priority over MEM/WB.
    always_comb begin
        fwd_rs1 = q.rs1_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == q.rs1)) begin
            fwd_rs1 = exmem_data;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == q.rs1)) begin
            fwd_rs1 = memwb_data;
        end
    end

    always_comb begin
        fwd_rs2 = q.rs2_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == q.rs2)) begin
            fwd_rs2 = exmem_data;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == q.rs2)) begin
            fwd_rs2 = memwb_data;
        end
    end

    assign input_data_1   = fwd_rs1;
    assign input_data_2   = q.alu_src ? q.imm : fwd_rs2;
    assign ex_store_data  = fwd_rs2;
    assign ex_valid       = q.valid;
    assign ex_pc          = q.pc;
    assign ex_alu_control = q.alu_control;
    assign ex_imm         = q.imm;
    assign ex_rd          = q.rd;
    assign ex_reg_write   = q.reg_write;
    assign ex_mem_read    = q.mem_read;
    assign ex_mem_write   = q.mem_write;
    assign ex_branch      = q.branch;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: forwarding priority, load-use bubbles, immediate path,
// and the reset/flush/stall update priority.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [3:0]  id_alu_control;
    logic        id_alu_src;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_branch;
    logic        flush;
    logic        stall;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_data;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_alu_control;
    logic [31:0] ex_imm;
    logic [31:0] input_data_1;
    logic [31:0] input_data_2;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        load_use_stall;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch),
        .flush(flush), .stall(stall),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_control(ex_alu_control), .ex_imm(ex_imm),
        .input_data_1(input_data_1), .input_data_2(input_data_2),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .load_use_stall(load_use_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                 input logic [3:0] alu, input logic src, input logic rw,
                                 input logic mr, input logic mw, input logic br);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_control = alu;
        id_alu_src = src; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_branch = br;
    endtask

    task automatic clearForwarding();
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_data = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_data = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clearForwarding();
        step(); step();
        checkOutput("rst_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("rst_op1", input_data_1, 32'h0);
        rst = 1'b0;
        checkOutput("post_rst_op2", input_data_2, 32'h0);
        checkOutput("post_rst_lus", {31'b0, load_use_stall}, 32'h0);

        // ADD x3, x1(5), x2(7)
        applyStimulus(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 4'd2, 0, 1, 0, 0, 0);
        step();
        checkOutput("add_op1", input_data_1, 32'd5);
        checkOutput("add_op2", input_data_2, 32'd7);
        checkOutput("add_rd", {27'b0, ex_rd}, 32'd3);
        checkOutput("add_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("add_pc", ex_pc, 32'h100);
        checkOutput("add_alu", {28'b0, ex_alu_control}, 32'd2);

        // Forwarding priority on registered rs1 = x4
        applyStimulus(1, 32'h104, 5'd4, 5'd6, 5'd7, 32'h33, 32'h44, 32'h0, 4'd0, 0, 1, 0, 0, 0);
        step();
        exmem_reg_write = 1; exmem_rd = 5'd4; exmem_data = 32'h11;
        memwb_reg_write = 1; memwb_rd = 5'd4; memwb_data = 32'h22;
        #1 checkOutput("fwd_exmem_wins", input_data_1, 32'h11);
        exmem_reg_write = 0;
        #1 checkOutput("fwd_memwb", input_data_1, 32'h22);
        memwb_rd = 5'd0;
        #1 checkOutput("fwd_rd0_none", input_data_1, 32'h33);
        checkOutput("fwd_op2_plain", input_data_2, 32'h44);
        clearForwarding();
        exmem_reg_write = 1; exmem_rd = 5'd6; exmem_data = 32'h55;
        #1 checkOutput("fwd_rs2_op2", input_data_2, 32'h55);
        checkOutput("fwd_rs2_store", ex_store_data, 32'h55);
        clearForwarding();

        // Load-use: LW x5 in EX, dependent reads x5 as rs2
        applyStimulus(1, 32'h200, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h8, 4'd0, 1, 1, 1, 0, 0);
        step();
        applyStimulus(1, 32'h204, 5'd8, 5'd5, 5'd9, 32'h1, 32'hDEAD, 32'h0, 4'd2, 0, 1, 0, 0, 0);
        #1 checkOutput("lu_detect", {31'b0, load_use_stall}, 32'h1);
        step();
        checkOutput("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("lu_bubble_memrd", {31'b0, ex_mem_read}, 32'h0);
        checkOutput("lu_clear", {31'b0, load_use_stall}, 32'h0);
        step();
        memwb_reg_write = 1; memwb_rd = 5'd5; memwb_data = 32'hCAFE;
        #1 checkOutput("lu_dep_pc", ex_pc, 32'h204);
        checkOutput("lu_dep_op2", input_data_2, 32'hCAFE);
        checkOutput("lu_dep_rd", {27'b0, ex_rd}, 32'd9);
        clearForwarding();

        // Immediate operand with forwarded rs2 kept for the store path
        applyStimulus(1, 32'h300, 5'd1, 5'd10, 5'd0, 32'h1, 32'h3, 32'hFFFFFFFC, 4'd0, 1, 0, 0, 1, 0);
        step();
        exmem_reg_write = 1; exmem_rd = 5'd10; exmem_data = 32'd9;
        #1 checkOutput("imm_op2", input_data_2, 32'hFFFFFFFC);
        checkOutput("imm_store", ex_store_data, 32'd9);
        checkOutput("imm_memwr", {31'b0, ex_mem_write}, 32'h1);
        clearForwarding();

        // Stall freezes contents while ID keeps changing
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h400 + 32'(i * 4), 5'd2, 5'd3, 5'd4, 32'(i), 32'(i), 32'(i), 4'd1, 0, 1, 0, 0, 1);
            step();
            checkOutput("stall_pc", ex_pc, 32'h300);
            checkOutput("stall_imm", ex_imm, 32'hFFFFFFFC);
        end

        flush = 1'b1;
        step();
        checkOutput("flush_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("flush_memwr", {31'b0, ex_mem_write}, 32'h0);
        checkOutput("flush_pc", ex_pc, 32'h0);
        flush = 1'b0; stall = 1'b0;

        // Non-valid capture masks side-effect controls
        applyStimulus(0, 32'h500, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, 4'd0, 0, 1, 1, 1, 1);
        step();
        checkOutput("inv_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("inv_regwr", {31'b0, ex_reg_write}, 32'h0);
        checkOutput("inv_memwr", {31'b0, ex_mem_write}, 32'h0);
        checkOutput("inv_branch", {31'b0, ex_branch}, 32'h0);

        // Reset mid-stream overrides stall
        applyStimulus(1, 32'h600, 5'd1, 5'd2, 5'd3, 32'h7, 32'h8, 32'h0, 4'd3, 0, 1, 0, 0, 1);
        step();
        checkOutput("pre_rst_branch", {31'b0, ex_branch}, 32'h1);
        rst = 1'b1; stall = 1'b1;
        step();
        checkOutput("rst_stall_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("rst_stall_pc", ex_pc, 32'h0);
        checkOutput("rst_stall_op1", input_data_1, 32'h0);
        checkOutput("rst_stall_regwr", {31'b0, ex_reg_write}, 32'h0);
        rst = 1'b0; stall = 1'b0;

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
